// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: mul/div FSM state
// encoding, operation selects and the hard-wired zero register.
package hazard_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   localparam logic MD_OP_MUL = 1'b0;
   localparam logic MD_OP_DIV = 1'b1;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic int unsigned md_cycles(input logic op,
                                             input int unsigned mul_c,
                                             input int unsigned div_c);
      return (op == MD_OP_DIV) ? div_c : mul_c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_seq.sv
// Multi-cycle mul/div sequencer: IDLE/BUSY FSM with a down-counter that
// holds EX for N-1 cycles and pulses o_done in the final cycle.
module muldiv_seq
   import hazard_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 16,
   parameter int unsigned CNT_W      = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_op,
   output logic o_hold,
   output logic o_busy,
   output logic o_done
);

   logic             r_state;
   logic [CNT_W-1:0] r_cnt;

   logic w_launch;
   logic w_count;
   logic w_last;

   // Gated by rst so that outputs sit at their defaults while reset is high.
   assign w_launch = ~rst & (r_state == ST_IDLE) & i_start;
   assign w_count  = ~rst & (r_state == ST_BUSY) & (r_cnt > CNT_W'(1));
   assign w_last   = ~rst & (r_state == ST_BUSY) & (r_cnt == CNT_W'(1));

   assign o_hold = w_launch | w_count;
   assign o_busy = o_hold;
   assign o_done = w_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else if (w_launch) begin
         r_state <= ST_BUSY;
         r_cnt   <= CNT_W'(md_cycles(i_op, MUL_CYCLES, DIV_CYCLES) - 1);
      end else if (w_count) begin
         r_cnt   <= r_cnt - CNT_W'(1);
      end else if (w_last) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch and
// jump flushes, mul/div EX hold. Optional perf counters under HAZARD_PERF_EN.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 16,
   parameter int unsigned CNT_W      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic       ID_UsesRs,
   input  logic       ID_UsesRt,
   input  logic       ID_Jump,
   input  logic       EX_MemRead,
   input  logic       EX_RegWrite,
   input  logic [4:0] EX_WriteRegister,
   input  logic       EX_BranchTaken,
   input  logic       EX_MulDivStart,
   input  logic       EX_MulDivOp,
   output logic       PC_Write,
   output logic       IF_ID_Write,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Write,
   output logic       ID_EX_Flush,
   output logic       EX_MEM_Bubble,
   output logic       MD_Busy,
   output logic       MD_Done
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_events
`endif
);

   logic w_hold;
   logic w_md_start;
   logic w_rs_hit;
   logic w_rt_hit;
   logic w_load_use;

   // A taken branch squashes the mul/div sitting in EX, so it never launches.
   assign w_md_start = EX_MulDivStart & ~EX_BranchTaken;

   muldiv_seq #(
      .MUL_CYCLES(MUL_CYCLES),
      .DIV_CYCLES(DIV_CYCLES),
      .CNT_W     (CNT_W)
   ) u_muldiv_seq (
      .clk    (clk),
      .rst    (rst),
      .i_start(w_md_start),
      .i_op   (EX_MulDivOp),
      .o_hold (w_hold),
      .o_busy (MD_Busy),
      .o_done (MD_Done)
   );

   assign w_rs_hit   = ID_UsesRs & (ID_Rs == EX_WriteRegister);
   assign w_rt_hit   = ID_UsesRt & (ID_Rt == EX_WriteRegister);
   assign w_load_use = EX_MemRead & EX_RegWrite &
                       (EX_WriteRegister != REG_ZERO) & (w_rs_hit | w_rt_hit);

   always_comb begin
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Write   = 1'b1;
      ID_EX_Flush   = 1'b0;
      EX_MEM_Bubble = 1'b0;
      if (!rst) begin
         if (w_hold) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
         end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
         end else if (w_load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
         end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (!PC_Write)
            r_perf_stall <= r_perf_stall + 32'd1;
         if (IF_ID_Flush | ID_EX_Flush)
            r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign perf_stall_cycles = r_perf_stall;
   assign perf_flush_events = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

   localparam int MULC = 4;
   localparam int DIVC = 16;

   // Output vector order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
   // ID_EX_Flush, EX_MEM_Bubble, MD_Busy, MD_Done
   localparam logic [7:0] O_DEF    = 8'b1101_0000;
   localparam logic [7:0] O_HOLD   = 8'b0000_0110;
   localparam logic [7:0] O_BRANCH = 8'b1111_1000;
   localparam logic [7:0] O_LU     = 8'b0001_1000;
   localparam logic [7:0] O_JUMP   = 8'b1111_0000;
   localparam logic [7:0] O_DONE   = 8'b1101_0001;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_Rs, ID_Rt, EX_WriteRegister;
   logic       ID_UsesRs, ID_UsesRt, ID_Jump;
   logic       EX_MemRead, EX_RegWrite, EX_BranchTaken;
   logic       EX_MulDivStart, EX_MulDivOp;
   logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
   logic       EX_MEM_Bubble, MD_Busy, MD_Done;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

   int tests = 0;
   int fails = 0;

   // Reference model: length of the running op (0 = none) and 1-based cycle index
   int          md_len = 0;
   int          md_k   = 0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .MUL_CYCLES(MULC),
      .DIV_CYCLES(DIVC),
      .CNT_W     (5)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ID_Rs           (ID_Rs),
      .ID_Rt           (ID_Rt),
      .ID_UsesRs       (ID_UsesRs),
      .ID_UsesRt       (ID_UsesRt),
      .ID_Jump         (ID_Jump),
      .EX_MemRead      (EX_MemRead),
      .EX_RegWrite     (EX_RegWrite),
      .EX_WriteRegister(EX_WriteRegister),
      .EX_BranchTaken  (EX_BranchTaken),
      .EX_MulDivStart  (EX_MulDivStart),
      .EX_MulDivOp     (EX_MulDivOp),
      .PC_Write        (PC_Write),
      .IF_ID_Write     (IF_ID_Write),
      .IF_ID_Flush     (IF_ID_Flush),
      .ID_EX_Write     (ID_EX_Write),
      .ID_EX_Flush     (ID_EX_Flush),
      .EX_MEM_Bubble   (EX_MEM_Bubble),
      .MD_Busy         (MD_Busy),
      .MD_Done         (MD_Done)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cycles(perf_stall_cycles),
      .perf_flush_events(perf_flush_events)
`endif
   );

   function automatic logic [7:0] dut_out();
      return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
              ID_EX_Flush, EX_MEM_Bubble, MD_Busy, MD_Done};
   endfunction

   function automatic logic [7:0] model_out();
      logic hold, done, lu;
      logic [7:0] o;
      hold = 1'b0;
      done = 1'b0;
      if (rst) return O_DEF;
      if (md_len != 0) begin
         if (md_k < md_len) hold = 1'b1;
         else               done = 1'b1;
      end else if (EX_MulDivStart && !EX_BranchTaken) begin
         hold = 1'b1;
      end
      lu = EX_MemRead && EX_RegWrite && (EX_WriteRegister != 0) &&
           ((ID_UsesRs && ID_Rs == EX_WriteRegister) ||
            (ID_UsesRt && ID_Rt == EX_WriteRegister));
      if (hold)                o = O_HOLD;
      else if (EX_BranchTaken) o = O_BRANCH;
      else if (lu)             o = O_LU;
      else if (ID_Jump)        o = O_JUMP;
      else                     o = O_DEF;
      o[0] = done;
      return o;
   endfunction

   // Advance one clock, updating the model with the inputs seen at the edge.
   task automatic tick();
      logic [7:0] e;
      e = model_out();
      @(posedge clk);
      if (rst) begin
         md_len  = 0;
         m_stall = '0;
         m_flush = '0;
      end else begin
         if (!e[7]) m_stall = m_stall + 32'd1;
         if (e[5] || e[3]) m_flush = m_flush + 32'd1;
         if (md_len != 0) begin
            if (md_k == md_len) md_len = 0;
            else                md_k   = md_k + 1;
         end else if (EX_MulDivStart && !EX_BranchTaken) begin
            md_len = EX_MulDivOp ? DIVC : MULC;
            md_k   = 2;
         end
      end
      #1;
   endtask

   task automatic clr_in();
      ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 0; ID_UsesRt = 0; ID_Jump = 0;
      EX_MemRead = 0; EX_RegWrite = 0; EX_WriteRegister = '0;
      EX_BranchTaken = 0; EX_MulDivStart = 0; EX_MulDivOp = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clr_in();
      EX_MulDivStart = 1'b1;
      ID_Jump = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if (dut_out() !== O_DEF) begin
            fails++;
            $display("FAIL reset cyc%0d: got %b want %b", i, dut_out(), O_DEF);
         end
         tick();
      end
      rst = 1'b0;
      clr_in();
      @(negedge clk);
      tests++;
      if (dut_out() !== O_DEF) begin
         fails++;
         $display("FAIL reset_idle: got %b want %b", dut_out(), O_DEF);
      end
`ifdef HAZARD_PERF_EN
      tests++;
      if (perf_stall_cycles !== 32'd0 || perf_flush_events !== 32'd0) begin
         fails++;
         $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cycles, perf_flush_events);
      end
`endif
      tick();
   endtask

   task automatic test_load_use();
      logic [7:0] want [3];
      want[0] = O_LU; want[1] = O_DEF; want[2] = O_DEF;
      for (int i = 0; i < 3; i++) begin
         clr_in();
         ID_UsesRs = 1; ID_Rs = 5'd8; ID_UsesRt = 1; ID_Rt = 5'd3;
         if (i == 0) begin
            EX_MemRead = 1; EX_RegWrite = 1; EX_WriteRegister = 5'd8;
         end else if (i == 2) begin
            ID_Rs = 5'd0;
            EX_MemRead = 1; EX_RegWrite = 1; EX_WriteRegister = 5'd0;
         end
         @(negedge clk);
         tests++;
         if (dut_out() !== want[i]) begin
            fails++;
            $display("FAIL load_use step%0d: got %b want %b", i, dut_out(), want[i]);
         end
         tick();
      end
      clr_in();
   endtask

   task automatic test_muldiv(input logic op, input int n);
      int holds, dones;
      holds = 0;
      dones = 0;
      clr_in();
      EX_MulDivStart = 1; EX_MulDivOp = op;
      for (int i = 1; i <= n + 1; i++) begin
         if (i == n + 1) clr_in();
         @(negedge clk);
         tests++;
         if (dut_out() !== model_out()) begin
            fails++;
            $display("FAIL muldiv op%0d cyc%0d: got %b want %b", op, i, dut_out(), model_out());
         end
         if (MD_Busy && EX_MEM_Bubble && !PC_Write) holds++;
         if (MD_Done) begin
            dones++;
            tests++;
            if (i != n) begin
               fails++;
               $display("FAIL muldiv_done_cycle op%0d: got %0d want %0d", op, i, n);
            end
         end
         tick();
      end
      tests++;
      if (holds != n - 1 || dones != 1) begin
         fails++;
         $display("FAIL muldiv_counts op%0d: got hold=%0d done=%0d want hold=%0d done=1",
                  op, holds, dones, n - 1);
      end
   endtask

   task automatic test_branch();
      clr_in();
      EX_BranchTaken = 1; ID_Jump = 1;
      EX_MemRead = 1; EX_RegWrite = 1; EX_WriteRegister = 5'd5;
      ID_UsesRt = 1; ID_Rt = 5'd5;
      @(negedge clk);
      tests++;
      if (dut_out() !== O_BRANCH) begin
         fails++;
         $display("FAIL branch_jump: got %b want %b", dut_out(), O_BRANCH);
      end
      tick();
      clr_in();
      EX_BranchTaken = 1; EX_MulDivStart = 1; EX_MulDivOp = 1;
      @(negedge clk);
      tests++;
      if (dut_out() !== O_BRANCH) begin
         fails++;
         $display("FAIL branch_start: got %b want %b", dut_out(), O_BRANCH);
      end
      tick();
      clr_in();
      @(negedge clk);
      tests++;
      if (dut_out() !== O_DEF) begin
         fails++;
         $display("FAIL branch_start_after: got %b want %b", dut_out(), O_DEF);
      end
      tick();
   endtask

   task automatic test_jump_load_use();
      clr_in();
      ID_Jump = 1; ID_UsesRs = 1; ID_Rs = 5'd12;
      EX_MemRead = 1; EX_RegWrite = 1; EX_WriteRegister = 5'd12;
      @(negedge clk);
      tests++;
      if (dut_out() !== O_LU) begin
         fails++;
         $display("FAIL jump_lu_stall: got %b want %b", dut_out(), O_LU);
      end
      tick();
      EX_MemRead = 0; EX_RegWrite = 0; EX_WriteRegister = 5'd0;
      @(negedge clk);
      tests++;
      if (dut_out() !== O_JUMP) begin
         fails++;
         $display("FAIL jump_lu_retry: got %b want %b", dut_out(), O_JUMP);
      end
      tick();
      clr_in();
   endtask

   task automatic test_reset_busy();
      clr_in();
      EX_MulDivStart = 1; EX_MulDivOp = 1;
      @(negedge clk);
      tests++;
      if (dut_out() !== O_HOLD) begin
         fails++;
         $display("FAIL rstbusy_start: got %b want %b", dut_out(), O_HOLD);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (dut_out() !== O_DEF) begin
         fails++;
         $display("FAIL rstbusy_during: got %b want %b", dut_out(), O_DEF);
      end
      tick();
      rst = 1'b0;
      clr_in();
      for (int i = 0; i < DIVC + 2; i++) begin
         @(negedge clk);
         tests++;
         if (dut_out() !== O_DEF) begin
            fails++;
            $display("FAIL rstbusy_after cyc%0d: got %b want %b", i, dut_out(), O_DEF);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      rst = 1'b1;
      clr_in();
      tick();
      rst = 1'b0;
      for (int i = 1; i <= DIVC + MULC + 1; i++) begin
         clr_in();
         if (i <= DIVC) begin
            EX_MulDivStart = 1; EX_MulDivOp = 1;
         end else if (i <= DIVC + MULC) begin
            EX_MulDivStart = 1; EX_MulDivOp = 0;
         end
         @(negedge clk);
         tests++;
         if (dut_out() !== model_out()) begin
            fails++;
            $display("FAIL b2b cyc%0d: got %b want %b", i, dut_out(), model_out());
         end
         if (i == DIVC || i == DIVC + 1) begin
            tests++;
            if (dut_out() !== ((i == DIVC) ? O_DONE : O_HOLD)) begin
               fails++;
               $display("FAIL b2b_handover cyc%0d: got %b want %b", i, dut_out(),
                        (i == DIVC) ? O_DONE : O_HOLD);
            end
         end
         tick();
      end
`ifdef HAZARD_PERF_EN
      tests++;
      if (perf_stall_cycles !== 32'd18) begin
         fails++;
         $display("FAIL b2b_perf_stall: got %0d want 18", perf_stall_cycles);
      end
`endif
      clr_in();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst              = ($urandom_range(0, 63) == 0);
         ID_Rs            = 5'($urandom_range(0, 3));
         ID_Rt            = 5'($urandom_range(0, 3));
         ID_UsesRs        = 1'($urandom);
         ID_UsesRt        = 1'($urandom);
         ID_Jump          = ($urandom_range(0, 3) == 0);
         EX_MemRead       = 1'($urandom);
         EX_RegWrite      = ($urandom_range(0, 3) != 0);
         EX_WriteRegister = 5'($urandom_range(0, 3));
         EX_BranchTaken   = ($urandom_range(0, 7) == 0);
         EX_MulDivStart   = ($urandom_range(0, 5) == 0);
         EX_MulDivOp      = 1'($urandom);
         @(negedge clk);
         tests++;
         if (dut_out() !== model_out()) begin
            fails++;
            $display("FAIL random cyc%0d: got %b want %b", i, dut_out(), model_out());
         end
`ifdef HAZARD_PERF_EN
         tests++;
         if (perf_stall_cycles !== m_stall || perf_flush_events !== m_flush) begin
            fails++;
            $display("FAIL random_perf cyc%0d: got %0d/%0d want %0d/%0d", i,
                     perf_stall_cycles, perf_flush_events, m_stall, m_flush);
         end
`endif
         tick();
      end
      rst = 1'b0;
      clr_in();
   endtask

   initial begin
      rst = 1'b1;
      clr_in();
      test_reset();
      test_load_use();
      test_muldiv(1'b0, MULC);
      test_muldiv(1'b1, DIVC);
      test_branch();
      test_jump_load_use();
      test_reset_busy();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards between ID and EX, squashes wrong-path instructions on taken branches and jumps, and holds the EX stage while a multi-cycle multiply/divide runs. Its outputs drive the PC, IF_ID and ID_EX write-enables and flushes, and the EX_MEM bubble insert. Forwarding of the EX operands is handled inside EX and is outside this block.

Parameters:
MUL_CYCLES, 4, total cycles a multiply occupies EX; must be >= 2
DIV_CYCLES, 16, total cycles a divide occupies EX; must be >= 2
CNT_W, 5, down-counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ID_Rs  input  5  rs field of the instruction in ID
ID_Rt  input  5  rt field of the instruction in ID
ID_UsesRs  input  1  ID instruction reads rs
ID_UsesRt  input  1  ID instruction reads rt
ID_Jump  input  1  ID instruction is j/jal/jr/jalr
EX_MemRead  input  1  EX instruction is a load
EX_RegWrite  input  1  EX instruction writes a register
EX_WriteRegister  input  5  destination register of the EX instruction
EX_BranchTaken  input  1  branch in EX resolved as taken
EX_MulDivStart  input  1  EX instruction is mult/div; level, held while the instruction sits in ID_EX
EX_MulDivOp  input  1  0 = multiply, 1 = divide
PC_Write  output  1  PC update enable
IF_ID_Write  output  1  IF_ID register write enable
IF_ID_Flush  output  1  zero IF_ID on the next edge
ID_EX_Write  output  1  ID_EX register write enable
ID_EX_Flush  output  1  load a bubble into ID_EX on the next edge
EX_MEM_Bubble  output  1  EX_MEM captures a nop (RegWrite=0, MemWrite=0, MemRead=0)
MD_Busy  output  1  mul/div in progress
MD_Done  output  1  single-cycle pulse in the final mul/div cycle; the result is valid this cycle

Behaviour:
- Default, no event: PC_Write = IF_ID_Write = ID_EX_Write = 1; all other outputs 0.
- While rst = 1: outputs are at default values; FSM goes to IDLE and cnt = 0 on the edge. Reset during BUSY aborts the operation with no MD_Done.
- FSM states: IDLE, BUSY. State and cnt are the only registers; all outputs are combinational from the state and the inputs.
- IDLE with EX_MulDivStart=1 and EX_BranchTaken=0:
  - cnt <= (EX_MulDivOp ? DIV_CYCLES : MUL_CYCLES) - 1; next state BUSY.
  - This cycle: hold = 1.
- BUSY:
  - EX_MulDivStart and EX_MulDivOp are ignored.
  - If cnt > 1: hold = 1 and cnt decrements.
  - If cnt == 1: MD_Done = 1, hold = 0, next state IDLE.
- An op of N cycles therefore asserts hold for N-1 consecutive cycles and MD_Done on cycle N. A back-to-back mul/div restarts from IDLE on the following cycle.
- hold = 1 forces:
  - PC_Write = IF_ID_Write = ID_EX_Write = 0
  - EX_MEM_Bubble = 1
  - MD_Busy = 1
  - all flushes 0
- Load-use condition: EX_MemRead & EX_RegWrite & (EX_WriteRegister != 0) & ((ID_UsesRs & ID_Rs == EX_WriteRegister) | (ID_UsesRt & ID_Rt == EX_WriteRegister)).
  - Response: PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1 for exactly one cycle.
  - The following cycle the load is in MEM, the condition clears and forwarding supplies the data.
- EX_BranchTaken: IF_ID_Flush = 1, ID_EX_Flush = 1, PC_Write = 1.
- ID_Jump: IF_ID_Flush = 1.
- Priority, highest first: rst > hold > EX_BranchTaken > load-use > ID_Jump.
  - Branch with start in the same cycle (illegal encoding): branch wins, start ignored, FSM stays IDLE.
  - Jump during a load-use stall: no IF_ID_Flush. The jump is re-evaluated on the next cycle.
  - Jump during a taken branch: covered by the branch flushes.
- Register 0 never triggers a load-use stall.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds output perf_stall_cycles (32), incremented on every cycle where PC_Write = 0, and output perf_flush_events (32), incremented on every cycle where IF_ID_Flush | ID_EX_Flush.
  - Both counters wrap modulo 2^32 and clear on rst.
  - The counters do not affect any other output.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - FSM state encoding (IDLE = 1'b0, BUSY = 1'b1)
  - MD_OP_MUL / MD_OP_DIV constants
  - REG_ZERO = 5'd0
- One sub-module, muldiv_seq: FSM plus down-counter; outputs hold, MD_Busy, MD_Done.
- Hazard, flush and priority logic stays in the top level.

Test Plan:
- Load-use: EX lw writes $8, ID add reads rs=$8 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle all defaults. Repeat with EX_WriteRegister=0 -> no stall.
- Mul: EX_MulDivStart=1, Op=0, MUL_CYCLES=4 -> hold and EX_MEM_Bubble for 3 cycles, MD_Done=1 in cycle 4, then defaults. Div with DIV_CYCLES=16 -> 15 hold cycles.
- Taken branch: EX_BranchTaken=1 with ID_Jump=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 in the same cycle.
- Jump under load-use: ID_Jump=1 with load-use active -> IF_ID_Flush=0 that cycle, IF_ID_Flush=1 on the next cycle.
- Reset in BUSY: rst=1 at cycle 2 of a div -> next cycle IDLE, outputs default, no MD_Done pulse.
- Back-to-back: div immediately followed by mul -> MD_Done, then a new hold starts on the next cycle. With HAZARD_PERF_EN defined, perf_stall_cycles = 15 + 3 = 18.
